// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per owner.
// A released owner always passes through one idle cycle before the next grant.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [2:0] idx_q;
  logic [7:0] hold_q;
  logic [7:0] grant_q;
  logic       valid_q;
  logic       timeout_q;

  logic [2:0] pick_d;
  logic       found_d;
  logic [2:0] cand;
  logic       relDone;
  logic       relDrop;
  logic       relHold;
  logic       relAny;

  // Scan requests starting at the pointer; the first set bit wins.
  always_comb begin
    found_d = 1'b0;
    pick_d  = ptr_q;
    cand    = '0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found_d && req[cand]) begin
        found_d = 1'b1;
        pick_d  = cand;
      end
    end
  end

  always_comb begin
    relDone = done;
    relDrop = !req[idx_q];
    relHold = (hold_q == HoldMax);
    relAny  = relDone | relDrop | relHold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && found_d) begin
            state_q <= OWN;
            idx_q   <= pick_d;
            grant_q <= 8'd1 << pick_d;
            valid_q <= 1'b1;
            hold_q  <= 8'd1;
          end
        end
        OWN: begin
          if (relAny) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= idx_q + 3'd1;
            // Timeout only flags a release caused purely by the hold limit.
            timeout_q <= relHold & ~relDone & ~relDrop;
          end else if (hold_q != HoldMax) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed scenario bench for rr_arbiter_8 built with MAX_HOLD=4.
// Observed vector is {grant, grant_idx, grant_valid, timeout}.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic [12:0] obs;

  int checks = 0;
  int failures = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {grant, grant_idx, grant_valid, timeout};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 8'hFF; done = 1'b1;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL reset_first: got %h want %h", obs, 13'h0); end
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL reset_hold: got %h want %h", obs, 13'h0); end
    rst = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
  endtask

  task automatic test_basic();
    pulse_reset();
    en = 1'b1; req = 8'b0010_0100;
    tick();
    checks++;
    if (obs !== {8'h04, 3'd2, 2'b10}) begin failures++; $display("FAIL basic_grant2: got %h want %h", obs, {8'h04, 3'd2, 2'b10}); end
    done = 1'b1;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL basic_release: got %h want %h", obs, 13'h0); end
    done = 1'b0;
    tick();
    checks++;
    if (obs !== {8'h20, 3'd5, 2'b10}) begin failures++; $display("FAIL basic_grant5: got %h want %h", obs, {8'h20, 3'd5, 2'b10}); end
    req = 8'h00;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL basic_drop: got %h want %h", obs, 13'h0); end
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL basic_idle_noreq: got %h want %h", obs, 13'h0); end
  endtask

  task automatic test_fairness();
    logic [7:0] eg;
    logic [2:0] ei;
    pulse_reset();
    en = 1'b1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      ei = 3'(i % 8);
      eg = 8'd1 << ei;
      tick();
      checks++;
      if (obs !== {eg, ei, 2'b10}) begin failures++; $display("FAIL fair_grant_%0d: got %h want %h", i, obs, {eg, ei, 2'b10}); end
      done = 1'b1;
      tick();
      checks++;
      if (obs !== 13'h0) begin failures++; $display("FAIL fair_gap_%0d: got %h want %h", i, obs, 13'h0); end
      done = 1'b0;
    end
    req = 8'h00; en = 1'b0;
  endtask

  task automatic test_timeout();
    pulse_reset();
    en = 1'b1; req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== {8'h01, 3'd0, 2'b10}) begin failures++; $display("FAIL hold_cycle_%0d: got %h want %h", i, obs, {8'h01, 3'd0, 2'b10}); end
    end
    tick();
    checks++;
    if (obs !== {8'h00, 3'd0, 2'b01}) begin failures++; $display("FAIL timeout_pulse: got %h want %h", obs, {8'h00, 3'd0, 2'b01}); end
    tick();
    checks++;
    if (obs !== {8'h01, 3'd0, 2'b10}) begin failures++; $display("FAIL timeout_regrant: got %h want %h", obs, {8'h01, 3'd0, 2'b10}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== {8'h01, 3'd0, 2'b10}) begin failures++; $display("FAIL rehold_%0d: got %h want %h", i, obs, {8'h01, 3'd0, 2'b10}); end
    end
    done = 1'b1;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL coincident_no_timeout: got %h want %h", obs, 13'h0); end
    req = 8'h00;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL done_in_idle: got %h want %h", obs, 13'h0); end
    done = 1'b0;
  endtask

  task automatic test_wrap();
    pulse_reset();
    en = 1'b1; req = 8'h80;
    tick();
    checks++;
    if (obs !== {8'h80, 3'd7, 2'b10}) begin failures++; $display("FAIL wrap_grant7: got %h want %h", obs, {8'h80, 3'd7, 2'b10}); end
    req = 8'h01;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL wrap_drop: got %h want %h", obs, 13'h0); end
    req = 8'h81;
    tick();
    checks++;
    if (obs !== {8'h01, 3'd0, 2'b10}) begin failures++; $display("FAIL wrap_grant0: got %h want %h", obs, {8'h01, 3'd0, 2'b10}); end
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;
  endtask

  task automatic test_enable();
    pulse_reset();
    en = 1'b1; req = 8'h08;
    tick();
    checks++;
    if (obs !== {8'h08, 3'd3, 2'b10}) begin failures++; $display("FAIL en_grant3: got %h want %h", obs, {8'h08, 3'd3, 2'b10}); end
    req = 8'hFF; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== {8'h08, 3'd3, 2'b10}) begin failures++; $display("FAIL en_low_hold_%0d: got %h want %h", i, obs, {8'h08, 3'd3, 2'b10}); end
    end
    done = 1'b1;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL en_low_release: got %h want %h", obs, 13'h0); end
    done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 13'h0) begin failures++; $display("FAIL en_low_idle_%0d: got %h want %h", i, obs, 13'h0); end
    end
    en = 1'b1;
    tick();
    checks++;
    if (obs !== {8'h10, 3'd4, 2'b10}) begin failures++; $display("FAIL en_high_grant4: got %h want %h", obs, {8'h10, 3'd4, 2'b10}); end
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00; en = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    en = 1'b1; req = 8'h08;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h10;
    tick();
    checks++;
    if (obs !== {8'h10, 3'd4, 2'b10}) begin failures++; $display("FAIL rmid_grant4: got %h want %h", obs, {8'h10, 3'd4, 2'b10}); end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs !== {8'h10, 3'd4, 2'b10}) begin failures++; $display("FAIL rmid_at_limit: got %h want %h", obs, {8'h10, 3'd4, 2'b10}); end
    done = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (obs !== 13'h0) begin failures++; $display("FAIL rmid_reset: got %h want %h", obs, 13'h0); end
    rst = 1'b0; done = 1'b0; req = 8'hFF;
    tick();
    checks++;
    if (obs !== {8'h01, 3'd0, 2'b10}) begin failures++; $display("FAIL rmid_from0: got %h want %h", obs, {8'h01, 3'd0, 2'b10}); end
    req = 8'h00; en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    test_reset();
    test_basic();
    test_fairness();
    test_timeout();
    test_wrap();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
